// File: rtl/mul8_share_sched_if.sv
// Bundle of client request, result and 4x4-core signals for mul8_share_sched.
// slave = the scheduler; master = clients plus the external core.
interface mul8_share_sched_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [3:0]        core_a;
  logic [3:0]        core_b;
  logic [7:0]        core_p;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_prod;
  logic [IDW-1:0]    res_id;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, core_p, res_ready,
    output req_ready, core_a, core_b, res_valid, res_prod, res_id, busy
  );
  modport master (
    output req_valid, req_a, req_b, core_p, res_ready,
    input  req_ready, core_a, core_b, res_valid, res_prod, res_id, busy
  );
endinterface

// File: rtl/mul8_share_sched.sv
// Round-robin scheduler sharing one external 4x4 multiplier among NREQ 8x8 clients.
// Optional MUL8_SCHED_ZERO_SKIP_EN: zero operand bypasses CALC, result after one edge.
module mul8_share_sched #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  mul8_share_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [1:0]     step_q, step_d;
  logic [15:0]    acc_q, acc_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     a_q, a_d, b_q, b_d;
  logic           res_valid_q, res_valid_d;
  logic [15:0]    res_prod_q, res_prod_d;
  logic [IDW-1:0] res_id_q, res_id_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [7:0]     gnt_a, gnt_b;
  logic [3:0]     nib_a, nib_b;
  logic [15:0]    part;

  // Scan downward so the nearest valid at or after rr_q is the last (winning) hit.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  assign gnt_a = bus.req_a[8*int'(gnt_idx) +: 8];
  assign gnt_b = bus.req_b[8*int'(gnt_idx) +: 8];

  // step bit1 picks the a nibble, bit0 the b nibble; shift is the sum of both nibble weights
  assign nib_a = step_q[1] ? a_q[7:4] : a_q[3:0];
  assign nib_b = step_q[0] ? b_q[7:4] : b_q[3:0];

  always_comb begin
    case (step_q)
      2'd0:    part = {8'h00, bus.core_p};
      2'd3:    part = {bus.core_p, 8'h00};
      default: part = {4'h0, bus.core_p, 4'h0};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      acc_q       <= 16'h0000;
      rr_q        <= '0;
      id_q        <= '0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      res_valid_q <= 1'b0;
      res_prod_q  <= 16'h0000;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_prod_q  <= res_prod_d;
      res_id_q    <= res_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    rr_d        = rr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_prod_d  = res_prod_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          a_d     = gnt_a;
          b_d     = gnt_b;
          id_d    = gnt_idx;
          acc_d   = 16'h0000;
          step_d  = 2'd0;
          rr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          state_d = CALC;
`ifdef MUL8_SCHED_ZERO_SKIP_EN
          if (gnt_a == 8'h00 || gnt_b == 8'h00) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_prod_d  = 16'h0000;
            res_id_d    = gnt_idx;
          end
`endif
        end
      end
      CALC: begin
        acc_d  = acc_q + part;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          res_prod_d  = acc_q + part;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && gnt_found && !rst) bus.req_ready[gnt_idx] = 1'b1;
    bus.core_a    = (state_q == CALC) ? nib_a : 4'h0;
    bus.core_b    = (state_q == CALC) ? nib_b : 4'h0;
    bus.busy      = (state_q != IDLE);
    bus.res_valid = res_valid_q;
    bus.res_prod  = res_prod_q;
    bus.res_id    = res_id_q;
  end

endmodule
